// File: rtl/reg_file_sb.sv
// Purpose: integer register file with write-back bypass and per-register pending-write scoreboard.
// Latency: reads are combinational (0 cycles); writes and scoreboard updates land on the rising clk edge.
// Backpressure: stall holds issue while a consumed source or the destination has an unresolved producer.
//
// Ports: a1/a2 + use1/use2 read ports -> rd1/rd2; we3/a3/wd3 write-back port;
//        issue_valid/issue_rd issue request -> stall/issue_fire; busy/pend_cnt scoreboard state.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    a1,
    input  logic [AW-1:0]    a2,
    input  logic             use1,
    input  logic             use2,
    output logic [XLEN-1:0]  rd1,
    output logic [XLEN-1:0]  rd2,
    input  logic             we3,
    input  logic [AW-1:0]    a3,
    input  logic [XLEN-1:0]  wd3,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    output logic             stall,
    output logic             issue_fire,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      pend_cnt
);

    localparam int  CW     = AW + 1;
    localparam logic BYP_EN = (BYPASS != 0);

    logic [XLEN-1:0]  rf [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_nxt;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [CW-1:0]    pend_q;
    logic             wr_en;
    logic             raw1;
    logic             raw2;
    logic             waw;
    logic             set_en;
    logic             inc;
    logic             dec;

    // Writes to register 0 never take effect anywhere.
    assign wr_en = we3 && (a3 != '0);

    // Read ports: register 0 reads as zero; optional forward of write-back data.
    always_comb begin
        rd1 = '0;
        if (a1 != '0) begin
            if (BYP_EN && wr_en && (a3 == a1)) rd1 = wd3;
            else                               rd1 = rf[a1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (a2 != '0) begin
            if (BYP_EN && wr_en && (a3 == a2)) rd2 = wd3;
            else                               rd2 = rf[a2];
        end
    end

    // A same-cycle write-back resolves a RAW only when it is forwarded, but
    // always resolves a WAW because the new producer will re-set the bit.
    always_comb begin
        raw1       = use1 && busy_q[a1] && !(BYP_EN && we3 && (a3 == a1));
        raw2       = use2 && busy_q[a2] && !(BYP_EN && we3 && (a3 == a2));
        waw        = issue_valid && busy_q[issue_rd] && !(we3 && (a3 == issue_rd));
        stall      = issue_valid && (raw1 || raw2 || waw);
        issue_fire = issue_valid && !stall;
    end

    // Scoreboard next state: set is applied after clear so a collision keeps the bit.
    always_comb begin
        set_en  = issue_fire && (issue_rd != '0);
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[issue_rd] = 1'b1;
        if (wr_en)  clr_vec[a3]       = 1'b1;
        busy_nxt    = (busy_q & ~clr_vec) | set_vec;
        busy_nxt[0] = 1'b0;
        // Count moves only on real bit transitions so it always equals popcount(busy).
        inc = set_en && !busy_q[issue_rd];
        dec = wr_en && busy_q[a3] && !(set_en && (issue_rd == a3));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wr_en) begin
            rf[a3] <= wd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            busy_q <= busy_nxt;
            pend_q <= pend_q + CW'(inc) - CW'(dec);
        end
    end

    assign busy     = busy_q;
    assign pend_cnt = pend_q;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

    localparam int XL = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] a1, a2, a3, issue_rd;
    logic          use1, use2, we3, issue_valid;
    logic [XL-1:0] wd3;

    // index 0: BYPASS=1 instance, index 1: BYPASS=0 instance
    logic [XL-1:0] rd1_o [2];
    logic [XL-1:0] rd2_o [2];
    logic          stall_o [2];
    logic          fire_o [2];
    logic [NR-1:0] busy_o [2];
    logic [AW:0]   pend_o [2];

    reg_file_sb #(.XLEN(XL), .NREGS(NR), .AW(AW), .BYPASS(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .use1(use1), .use2(use2),
        .rd1(rd1_o[0]), .rd2(rd2_o[0]), .we3(we3), .a3(a3), .wd3(wd3),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .stall(stall_o[0]),
        .issue_fire(fire_o[0]), .busy(busy_o[0]), .pend_cnt(pend_o[0])
    );

    reg_file_sb #(.XLEN(XL), .NREGS(NR), .AW(AW), .BYPASS(0)) u_b0 (
        .clk(clk), .rst_n(rst_n), .a1(a1), .a2(a2), .use1(use1), .use2(use2),
        .rd1(rd1_o[1]), .rd2(rd2_o[1]), .we3(we3), .a3(a3), .wd3(wd3),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .stall(stall_o[1]),
        .issue_fire(fire_o[1]), .busy(busy_o[1]), .pend_cnt(pend_o[1])
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference state: architectural values and a set of pending registers.
    logic [XL-1:0] m_rf [2][NR];
    bit            m_busy [2][NR];

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[inst%0d] got=%0h expected=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic logic [XL-1:0] e_rd(input int k, input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (k == 0 && we3 && a3 == a) return wd3;
        return m_rf[k][a];
    endfunction

    function automatic bit e_raw(input int k, input logic u, input logic [AW-1:0] a);
        return u && m_busy[k][a] && !(k == 0 && we3 && a3 == a);
    endfunction

    function automatic bit e_stall(input int k);
        bit waw;
        waw = issue_valid && m_busy[k][issue_rd] && !(we3 && a3 == issue_rd);
        return issue_valid && (e_raw(k, use1, a1) || e_raw(k, use2, a2) || waw);
    endfunction

    function automatic bit e_fire(input int k);
        return issue_valid && !e_stall(k);
    endfunction

    function automatic logic [NR-1:0] e_busy(input int k);
        logic [NR-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    function automatic int e_pend(input int k);
        int n;
        n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_busy[k][i]);
        return n;
    endfunction

    // Compare every cycle mid-low-phase, then advance the model on the rising edge.
    always begin
        @(negedge clk);
        #3;
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("rd1",   k, 64'(rd1_o[k]),   64'(e_rd(k, a1)));
                chk("rd2",   k, 64'(rd2_o[k]),   64'(e_rd(k, a2)));
                chk("stall", k, 64'(stall_o[k]), 64'(e_stall(k)));
                chk("fire",  k, 64'(fire_o[k]),  64'(e_fire(k)));
                chk("busy",  k, 64'(busy_o[k]),  64'(e_busy(k)));
                chk("pend",  k, 64'(pend_o[k]),  64'(e_pend(k)));
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            bit f;
            f = e_fire(k);
            if (!rst_n) begin
                for (int i = 0; i < NR; i++) begin
                    m_rf[k][i]   = '0;
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                if (we3 && a3 != 0) begin
                    m_rf[k][a3]   = wd3;
                    m_busy[k][a3] = 1'b0;
                end
                if (f && issue_rd != 0) m_busy[k][issue_rd] = 1'b1;
            end
        end
    end

    task automatic idle();
        rst_n = 1'b1; a1 = '0; a2 = '0; a3 = '0; issue_rd = '0;
        use1 = 1'b0; use2 = 1'b0; we3 = 1'b0; issue_valid = 1'b0; wd3 = '0;
    endtask

    // Next cycle: inputs change shortly after the falling edge.
    task automatic nx();
        @(negedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        idle();
        a1 = 5;
        chk_en = 1'b1;
        #3;
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", k, 64'(busy_o[k]), 64'h0);
            chk("rst_pend", k, 64'(pend_o[k]), 64'h0);
            chk("rst_rd1",  k, 64'(rd1_o[k]),  64'h0);
            chk("rst_stall", k, 64'(stall_o[k]), 64'h0);
        end

        // Reset wipes stored data.
        nx(); we3 = 1; a3 = 5; wd3 = 32'hDEADBEEF;
        nx(); a1 = 5; rst_n = 0; #3;
        for (int k = 0; k < 2; k++) chk("pre_rst_rd1", k, 64'(rd1_o[k]), 64'hDEADBEEF);
        nx(); a1 = 5; #3;
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_rd1",  k, 64'(rd1_o[k]), 64'h0);
            chk("post_rst_pend", k, 64'(pend_o[k]), 64'h0);
        end

        // Register 0 ignores writes and issues.
        nx(); we3 = 1; a3 = 0; wd3 = 32'hFFFFFFFF; issue_valid = 1; issue_rd = 0; #3;
        for (int k = 0; k < 2; k++) chk("x0_fire", k, 64'(fire_o[k]), 64'h1);
        nx(); a1 = 0; #3;
        for (int k = 0; k < 2; k++) begin
            chk("x0_rd1",  k, 64'(rd1_o[k]),  64'h0);
            chk("x0_busy", k, 64'(busy_o[k]), 64'h0);
            chk("x0_pend", k, 64'(pend_o[k]), 64'h0);
        end

        // RAW on x7, resolved by a same-cycle write-back.
        nx(); issue_valid = 1; issue_rd = 7;
        nx(); issue_valid = 1; issue_rd = 0; use1 = 1; a1 = 7; #3;
        for (int k = 0; k < 2; k++) chk("raw_stall", k, 64'(stall_o[k]), 64'h1);
        #1; we3 = 1; a3 = 7; wd3 = 32'h1234; #2;
        chk("raw_byp_stall", 0, 64'(stall_o[0]), 64'h0);
        chk("raw_byp_rd1",   0, 64'(rd1_o[0]),   64'h1234);
        chk("raw_nobyp_stall", 1, 64'(stall_o[1]), 64'h1);
        nx(); issue_valid = 1; issue_rd = 0; use1 = 1; a1 = 7; #3;
        chk("raw_nobyp_stall2", 1, 64'(stall_o[1]), 64'h0);
        chk("raw_nobyp_rd1",    1, 64'(rd1_o[1]),   64'h1234);

        // Set/clear collision on x9.
        nx(); issue_valid = 1; issue_rd = 9;
        nx(); issue_valid = 1; issue_rd = 9; we3 = 1; a3 = 9; wd3 = 32'h9999; #3;
        for (int k = 0; k < 2; k++) begin
            chk("col_fire", k, 64'(fire_o[k]), 64'h1);
            chk("col_pend", k, 64'(pend_o[k]), 64'h1);
        end
        nx(); a1 = 9; #3;
        for (int k = 0; k < 2; k++) begin
            chk("col_busy9", k, 64'(busy_o[k][9]), 64'h1);
            chk("col_pend2", k, 64'(pend_o[k]),    64'h1);
            chk("col_rd1",   k, 64'(rd1_o[k]),     64'h9999);
        end

        // WAW on x4.
        nx(); issue_valid = 1; issue_rd = 4;
        nx(); issue_valid = 1; issue_rd = 4; #3;
        for (int k = 0; k < 2; k++) begin
            chk("waw_stall", k, 64'(stall_o[k]), 64'h1);
            chk("waw_fire",  k, 64'(fire_o[k]),  64'h0);
        end
        #1; we3 = 1; a3 = 4; wd3 = 32'h44; #2;
        for (int k = 0; k < 2; k++) chk("waw_wb_stall", k, 64'(stall_o[k]), 64'h0);
        nx(); #3;
        for (int k = 0; k < 2; k++) chk("waw_busy4", k, 64'(busy_o[k][4]), 64'h1);

        // Fill and drain the scoreboard.
        nx(); rst_n = 0;
        for (int i = 1; i < NR; i++) begin
            nx(); issue_valid = 1; issue_rd = AW'(i);
        end
        nx(); #3;
        for (int k = 0; k < 2; k++) begin
            chk("full_pend", k, 64'(pend_o[k]), 64'd31);
            chk("full_busy", k, 64'(busy_o[k]), 64'hFFFFFFFE);
        end
        for (int i = 1; i < NR; i++) begin
            nx(); we3 = 1; a3 = AW'(i); wd3 = $urandom;
        end
        nx(); we3 = 1; a3 = 3; wd3 = 32'h33; #3;
        for (int k = 0; k < 2; k++) chk("empty_pend", k, 64'(pend_o[k]), 64'h0);
        nx(); #3;
        for (int k = 0; k < 2; k++) chk("extra_wb_pend", k, 64'(pend_o[k]), 64'h0);

        // Random traffic, narrow address range most of the time to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            bit narrow;
            nx();
            narrow      = ($urandom_range(0, 3) != 0);
            rst_n       = ($urandom_range(0, 149) != 0);
            a1          = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            a2          = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            a3          = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            issue_rd    = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
            use1        = $urandom_range(0, 1) != 0;
            use2        = $urandom_range(0, 1) != 0;
            we3         = $urandom_range(0, 2) != 0;
            issue_valid = $urandom_range(0, 4) < 3;
            wd3         = $urandom;
        end

        nx(); #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
